// File: rtl/lcd_fb_sched.sv
// Framebuffer scan-out scheduler: prefetches line n+1 into a ping-pong line buffer while line n
// is displayed, and gives a host write port the RAM cycles the prefetch leaves idle.
module lcd_fb_sched #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144,
  parameter int LINES  = 154
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  input  logic [7:0]  px_x,
  output logic [1:0]  px_val,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [12:0] host_addr,
  input  logic [7:0]  host_data,
  output logic [12:0] ram_addr,
  output logic        ram_re,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        underrun
);

  localparam int BPL      = WIDTH / 4;
  localparam int FB_BYTES = HEIGHT * BPL;
  localparam int IW       = $clog2(BPL);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state_q;
  logic            disp_sel_q;
  logic [IW-1:0]   cnt_q;
  logic            rd_pend_q;
  logic [IW-1:0]   rd_idx_q;
  logic [12:0]     ram_addr_q;
  logic            ram_re_q;
  logic            ram_we_q;
  logic [7:0]      ram_wdata_q;
  logic            underrun_q;
  logic [7:0]      bank_q [2][BPL];

  logic [7:0]      tgt_d;
  logic            fetch_d;
  logic [12:0]     base_d;
  logic            host_fire;
  logic [7:0]      px_byte;

  // Target line wraps from the last vblank line back to line 0.
  always_comb begin
    tgt_d   = (line_y == 8'(LINES - 1)) ? 8'd0 : line_y + 8'd1;
    fetch_d = (tgt_d < 8'(HEIGHT));
    base_d  = 13'(tgt_d) * 13'(BPL);
  end

  assign host_ready = rst_n && (state_q == IDLE) && !line_start;
  assign host_fire  = host_valid && host_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      disp_sel_q  <= 1'b0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      ram_addr_q  <= '0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      underrun_q  <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < BPL; i++)
          bank_q[b][i] <= '0;
    end else begin
      ram_re_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      // A read still in flight when a new line starts belongs to the aborted fetch; drop it.
      rd_pend_q <= ram_re_q && !line_start;
      rd_idx_q  <= cnt_q;
      if (rd_pend_q)
        bank_q[~disp_sel_q][rd_idx_q] <= ram_rdata;

      if (line_start) begin
        if (state_q != IDLE)
          underrun_q <= 1'b1;
        disp_sel_q <= ~disp_sel_q;
        cnt_q      <= '0;
        if (fetch_d) begin
          state_q    <= FETCH;
          ram_re_q   <= 1'b1;
          ram_addr_q <= base_d;
        end else begin
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          FETCH: begin
            if (cnt_q == IW'(BPL - 1)) begin
              state_q <= DRAIN;
            end else begin
              ram_re_q   <= 1'b1;
              ram_addr_q <= ram_addr_q + 13'd1;
              cnt_q      <= cnt_q + IW'(1);
            end
          end
          DRAIN: state_q <= IDLE;
          default: begin
            if (host_fire) begin
              ram_we_q    <= (host_addr < 13'(FB_BYTES));
              ram_addr_q  <= host_addr;
              ram_wdata_q <= host_data;
            end
          end
        endcase
      end
    end
  end

  // Pixel 0 sits in the top two bits of each byte.
  always_comb begin
    px_byte = bank_q[disp_sel_q][IW'(px_x >> 2)];
    px_val  = 2'b00;
    if (px_x < 8'(WIDTH)) begin
      case (px_x[1:0])
        2'd0:    px_val = px_byte[7:6];
        2'd1:    px_val = px_byte[5:4];
        2'd2:    px_val = px_byte[3:2];
        default: px_val = px_byte[1:0];
      endcase
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_re    = ram_re_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign underrun  = underrun_q;

endmodule
